gpr_wb_arbiter: RTL and testbench
=================================

# gpr_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32×32 general-purpose register file. It shares the register file's single write port between the pipeline writeback stage, which always has priority, and a long-latency result source such as a multi-cycle multiply/divide unit or a coprocessor load. Long-latency results are queued in a small FIFO. The arbiter raises a stall to the pipeline when queued results starve. It also reports which registers have writes still queued, so the hazard unit can hold dependent instructions.

## Interface
Parameters:
- DEPTH, 4, long-latency FIFO entries (power of two, ≥2)
- STARVE_MAX, 8, consecutive ungranted cycles of a valid FIFO head before Stall is raised (≥1)

Ports:
- Clk  in  1  clock; all state updates on posedge
- Rst  in  1  asynchronous, active-low reset
- W_We  in  1  writeback-stage write request
- W_A3  in  5  writeback destination register
- W_WD  in  32  writeback data
- X_Valid  in  1  long-latency result valid
- X_Ready  out  1  FIFO can accept (= not full)
- X_A3  in  5  long-latency destination register
- X_WD  in  32  long-latency data
- Q1, Q2  in  5 each  decode-stage source registers to check
- Busy1, Busy2  out  1 each  a valid queued write targets Q1 / Q2
- Stall  out  1  request to freeze the writeback stage
- We  out  1  register file write enable
- A3  out  5  register file write address
- WD  out  32  register file write data

## Operation
- A W request counts only if W_We=1 and W_A3≠0. X pushes with A3=0 are accepted and stored invalid, so they never write.
- Grant per cycle:
  - If there is a W request, W is granted: We=1, A3=W_A3, WD=W_WD.
  - Otherwise, if the FIFO is non-empty, the head is granted and popped. We is the head's valid bit; A3/WD are the head fields.
  - Otherwise We=0 and A3/WD=0.
- Push: X_Valid && X_Ready enqueues {valid=1, X_A3, X_WD} at the tail. X_Ready depends only on registered occupancy, so there is no push-through on a full FIFO even when a pop occurs in the same cycle.
- Squash: a W grant to register r clears the valid bit of every stored entry with A3=r, because a pipeline write is always program-order newer. A squashed entry still occupies a pop slot and drains with We=0.
- An entry pushed in the same cycle as a matching W grant is not squashed.
- Busy1 = (Q1≠0) && any stored valid entry has A3==Q1. Busy2 is the same for Q2. The entry being pushed this cycle is excluded.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each cycle the FIFO is non-empty and the head is not granted.
  - Clears on a head grant or when the FIFO is empty.
- Stall is a register set when the counter equals STARVE_MAX, and cleared the cycle after a head grant.
- If W_We=1 while Stall=1, W still wins. The arbiter never drops a W write.

## Timing
- We/A3/WD are combinational from W inputs and registered FIFO state. They are stable before negedge Clk, where the register file samples them, and W writes land in the same cycle.
- Busy1/Busy2 are combinational from Q1/Q2 and registered state.
- An X result becomes eligible for grant the cycle after its push; minimum queue latency is 1 cycle.
- Stall asserts STARVE_MAX+1 cycles after the head first waits. It deasserts one cycle after the head grant.
- Reset (Rst=0, asynchronous) clears FIFO pointers, valid bits and counter, and drives Stall=0.
  - While Rst=0, We is forced to 0 and X_Ready is forced to 0.
  - Reset mid-queue discards all entries without writing them.

## Configuration
- GPR_ARB_TRACE_EN defined: every posedge with We=1 prints "$<A3> = <WD hex>" tagged W or X via $display.
- Not defined: no display statements are compiled; behaviour is otherwise identical.

## Test plan
- W_We=1, W_A3=5, W_WD=0x1234, FIFO empty -> We=1, A3=5, WD=0x1234 same cycle; Stall=0.
- Push X (A3=7, 0xAAAA), W idle -> next cycle We=1, A3=7, WD=0xAAAA. Busy1=1 for Q1=7 until pop, then 0.
- Push DEPTH entries with W_We=1 and W_A3=3 held busy -> X_Ready=0 after the fourth push. Stall rises after STARVE_MAX+1 waiting cycles. Dropping W_We drains the entries in order, 1 per cycle.
- Queue X (A3=9, 0x1), then W write A3=9, 0x2 -> the queued entry later drains with We=0, so r9 stays 0x2.
- X_A3=0 push and W_A3=0 request -> no register file write; Busy1=0 for Q1=0.
- Assert Rst low with 3 entries queued -> We=0, X_Ready=0, Stall=0 immediately. After release the FIFO is empty and Busy1/Busy2=0.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// Write-port arbiter for the 32x32 GPR file: writeback has priority, long-latency results queue in a FIFO.
// Optional macro GPR_ARB_TRACE_EN prints every register-file write.
module gpr_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        W_We,
    input  logic [4:0]  W_A3,
    input  logic [31:0] W_WD,
    input  logic        X_Valid,
    output logic        X_Ready,
    input  logic [4:0]  X_A3,
    input  logic [31:0] X_WD,
    input  logic [4:0]  Q1,
    input  logic [4:0]  Q2,
    output logic        Busy1,
    output logic        Busy2,
    output logic        Stall,
    output logic        We,
    output logic [4:0]  A3,
    output logic [31:0] WD
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX    = CW'(STARVE_MAX);
    localparam logic [AW:0]   FULLCNT = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] r_valid;
    logic [4:0]       r_a3 [DEPTH];
    logic [31:0]      r_wd [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [CW-1:0]    r_starve;
    logic             r_stall;

    logic [AW-1:0]    w_wIdx;
    logic [AW-1:0]    w_rIdx;
    logic             w_empty;
    logic             w_full;
    logic             w_wReq;
    logic             w_headGrant;
    logic             w_push;

    assign w_wIdx      = r_wptr[AW-1:0];
    assign w_rIdx      = r_rptr[AW-1:0];
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = ((r_wptr - r_rptr) == FULLCNT);
    assign w_wReq      = W_We && (W_A3 != 5'd0);
    assign w_headGrant = !w_wReq && !w_empty;
    assign X_Ready     = Rst && !w_full;
    assign w_push      = X_Valid && X_Ready;
    assign Stall       = r_stall;

    always_comb begin
        We = 1'b0;
        A3 = 5'd0;
        WD = 32'd0;
        if (w_wReq) begin
            We = 1'b1;
            A3 = W_A3;
            WD = W_WD;
        end else if (!w_empty) begin
            We = r_valid[w_rIdx];
            A3 = r_a3[w_rIdx];
            WD = r_wd[w_rIdx];
        end
        if (!Rst) begin
            We = 1'b0;
        end
    end

    // Empty and popped slots keep valid=0, so scanning every slot sees only stored live writes.
    always_comb begin
        Busy1 = 1'b0;
        Busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_a3[i] == Q1) && (Q1 != 5'd0)) Busy1 = 1'b1;
            if (r_valid[i] && (r_a3[i] == Q2) && (Q2 != 5'd0)) Busy2 = 1'b1;
        end
    end

    // The push assignment comes last so an entry entering alongside a matching W write survives.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_valid <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wReq && (r_a3[i] == W_A3)) r_valid[i] <= 1'b0;
            end
            if (w_headGrant) begin
                r_valid[w_rIdx] <= 1'b0;
                r_rptr          <= r_rptr + (AW + 1)'(1);
            end
            if (w_push) begin
                r_valid[w_wIdx] <= (X_A3 != 5'd0);
                r_wptr          <= r_wptr + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_a3[w_wIdx] <= X_A3;
            r_wd[w_wIdx] <= X_WD;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_empty || w_headGrant) begin
                r_starve <= '0;
            end else if (r_starve != SMAX) begin
                r_starve <= r_starve + CW'(1);
            end
            if (w_headGrant) begin
                r_stall <= 1'b0;
            end else if (r_starve == SMAX) begin
                r_stall <= 1'b1;
            end
        end
    end

`ifdef GPR_ARB_TRACE_EN
    always @(posedge Clk) begin
        if (We) $display("%s $%0d = %h", w_wReq ? "W" : "X", A3, WD);
    end
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed plus short random bench for gpr_wb_arbiter; a scoreboard queue holds the expected FIFO contents.
module tb_gpr_wb_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        W_We = 1'b0;
    logic [4:0]  W_A3 = '0;
    logic [31:0] W_WD = '0;
    logic        X_Valid = 1'b0;
    logic        X_Ready;
    logic [4:0]  X_A3 = '0;
    logic [31:0] X_WD = '0;
    logic [4:0]  Q1 = '0;
    logic [4:0]  Q2 = '0;
    logic        Busy1, Busy2, Stall, We;
    logic [4:0]  A3;
    logic [31:0] WD;

    gpr_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .Clk(Clk), .Rst(Rst),
        .W_We(W_We), .W_A3(W_A3), .W_WD(W_WD),
        .X_Valid(X_Valid), .X_Ready(X_Ready), .X_A3(X_A3), .X_WD(X_WD),
        .Q1(Q1), .Q2(Q2), .Busy1(Busy1), .Busy2(Busy2),
        .Stall(Stall), .We(We), .A3(A3), .WD(WD)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    string       stepName = "init";
    logic        capW, capHead, capPush;
    logic [4:0]  capWA3, capXA3;
    logic [31:0] capXWD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", stepName, tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wwe, input logic [4:0] wa3, input logic [31:0] wwd,
                                 input logic xv, input logic [4:0] xa3, input logic [31:0] xwd);
        W_We = wwe; W_A3 = wa3; W_WD = wwd;
        X_Valid = xv; X_A3 = xa3; X_WD = xwd;
    endtask

    // Expected grant and busy flags come from the scoreboard, which holds entries already stored.
    task automatic checkOutput();
        logic        eWe, eRdy, eB1, eB2;
        logic [4:0]  eA3;
        logic [31:0] eWD;
        @(negedge Clk);
        capW    = W_We && (W_A3 != 5'd0);
        capHead = !capW && (sb.size() > 0);
        eRdy    = (sb.size() < DEPTH);
        capPush = X_Valid && eRdy;
        capWA3  = W_A3; capXA3 = X_A3; capXWD = X_WD;
        eWe = 1'b0; eA3 = '0; eWD = '0;
        if (capW) begin
            eWe = 1'b1; eA3 = W_A3; eWD = W_WD;
        end else if (capHead) begin
            eWe = sb[0].v; eA3 = sb[0].a; eWD = sb[0].d;
        end
        eB1 = 1'b0; eB2 = 1'b0;
        foreach (sb[i]) begin
            if (sb[i].v && sb[i].a == Q1 && Q1 != 5'd0) eB1 = 1'b1;
            if (sb[i].v && sb[i].a == Q2 && Q2 != 5'd0) eB2 = 1'b1;
        end
        chk("We", 32'(We), 32'(eWe));
        chk("A3", 32'(A3), 32'(eA3));
        chk("WD", WD, eWD);
        chk("X_Ready", 32'(X_Ready), 32'(eRdy));
        chk("Busy1", 32'(Busy1), 32'(eB1));
        chk("Busy2", 32'(Busy2), 32'(eB2));
    endtask

    task automatic advance();
        @(posedge Clk);
        if (capW) foreach (sb[i]) if (sb[i].a == capWA3) sb[i].v = 1'b0;
        if (capHead) void'(sb.pop_front());
        if (capPush) sb.push_back('{v: (capXA3 != 5'd0), a: capXA3, d: capXWD});
        #1;
    endtask

    initial begin
        #2;
        stepName = "reset0";
        chk("We", 32'(We), 32'd0);
        chk("X_Ready", 32'(X_Ready), 32'd0);
        chk("Stall", 32'(Stall), 32'd0);
        @(negedge Clk); #1;
        Rst = 1'b1;
        @(posedge Clk); #1;

        stepName = "wbasic";
        applyStimulus(1, 5, 32'h1234, 0, 0, 0);
        checkOutput();
        chk("A3c", 32'(A3), 32'd5);
        chk("WDc", WD, 32'h1234);
        chk("Stall", 32'(Stall), 32'd0);
        advance();

        stepName = "xpush";
        Q1 = 5'd7;
        applyStimulus(0, 0, 0, 1, 7, 32'hAAAA);
        checkOutput();
        chk("Busy1c", 32'(Busy1), 32'd0);
        advance();
        stepName = "xpop";
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("Busy1c", 32'(Busy1), 32'd1);
        chk("WDc", WD, 32'hAAAA);
        advance();
        stepName = "xdone";
        checkOutput();
        chk("Busy1c", 32'(Busy1), 32'd0);
        advance();

        // Fill under a busy writeback port; the fifth push attempt meets a full FIFO.
        Q1 = 5'd10; Q2 = 5'd13;
        for (int c = 0; c <= 10; c++) begin
            stepName = $sformatf("fill%0d", c);
            applyStimulus(1, 3, 32'h33, c < 5, 5'(10 + c), 32'(32'h100 + c));
            checkOutput();
            chk("Rdy", 32'(X_Ready), 32'(c < 4));
            chk("Stall", 32'(Stall), 32'(c >= STARVE_MAX + 2));
            advance();
        end
        for (int d = 0; d <= 4; d++) begin
            stepName = $sformatf("drain%0d", d);
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput();
            chk("Stall", 32'(Stall), 32'(d == 0));
            if (d < 4) chk("A3c", 32'(A3), 32'(10 + d));
            advance();
        end

        stepName = "sq0";
        Q1 = 5'd9; Q2 = 5'd12;
        applyStimulus(1, 3, 32'h33, 1, 9, 32'h1);
        checkOutput(); advance();
        stepName = "sq1";
        applyStimulus(1, 9, 32'h2, 0, 0, 0);
        checkOutput();
        chk("Busy1c", 32'(Busy1), 32'd1);
        advance();
        stepName = "sq2";
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("Wec", 32'(We), 32'd0);
        chk("Busy1c", 32'(Busy1), 32'd0);
        advance();
        stepName = "samecyc0";
        applyStimulus(1, 12, 32'h5, 1, 12, 32'h77);
        checkOutput(); advance();
        stepName = "samecyc1";
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("Wec", 32'(We), 32'd1);
        chk("WDc", WD, 32'h77);
        advance();

        stepName = "zero0";
        Q1 = 5'd0;
        applyStimulus(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        checkOutput();
        chk("Wec", 32'(We), 32'd0);
        advance();
        stepName = "zero1";
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput();
        chk("Wec", 32'(We), 32'd0);
        chk("Busy1c", 32'(Busy1), 32'd0);
        advance();

        for (int r = 0; r < 40; r++) begin
            stepName = $sformatf("rand%0d", r);
            Q1 = 5'($urandom_range(0, 3));
            Q2 = 5'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            checkOutput(); advance();
        end
        for (int k = 0; k < DEPTH + 1; k++) begin
            stepName = $sformatf("flush%0d", k);
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput(); advance();
        end

        Q1 = 5'd20; Q2 = 5'd22;
        for (int k = 0; k < 3; k++) begin
            stepName = $sformatf("rq%0d", k);
            applyStimulus(1, 3, 32'h33, 1, 5'(20 + k), 32'(32'h200 + k));
            checkOutput(); advance();
        end
        stepName = "rqheld";
        applyStimulus(1, 3, 32'h33, 0, 0, 0);
        checkOutput();
        chk("Busy1c", 32'(Busy1), 32'd1);
        chk("Busy2c", 32'(Busy2), 32'd1);
        #2;
        Rst = 1'b0;
        #1;
        stepName = "rstmid";
        chk("We", 32'(We), 32'd0);
        chk("X_Ready", 32'(X_Ready), 32'd0);
        chk("Stall", 32'(Stall), 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        Rst = 1'b1;
        sb.delete();
        @(posedge Clk); #1;
        stepName = "postrst";
        checkOutput();
        chk("Busy1c", 32'(Busy1), 32'd0);
        chk("Busy2c", 32'(Busy2), 32'd0);
        chk("Wec", 32'(We), 32'd0);
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
